// File: rtl/controller_data_path_pkg.sv
// Shared definitions for the Tron core: instruction encodings, FSM states,
// flag bit positions and the instruction decoder used by the datapath.
package controller_data_path_pkg;

  localparam int DataWidth = 16;
  localparam int RegCount  = 16;

  localparam logic [3:0] OP_RR    = 4'b0000;
  localparam logic [3:0] OP_ANDI  = 4'b0001;
  localparam logic [3:0] OP_ORI   = 4'b0010;
  localparam logic [3:0] OP_XORI  = 4'b0011;
  localparam logic [3:0] OP_ADDI  = 4'b0101;
  localparam logic [3:0] OP_SHIFT = 4'b1000;
  localparam logic [3:0] OP_SUBI  = 4'b1001;
  localparam logic [3:0] OP_CMPI  = 4'b1011;
  localparam logic [3:0] OP_MOVI  = 4'b1101;
  localparam logic [3:0] OP_LUI   = 4'b1111;

  localparam logic [3:0] EXT_AND = 4'b0001;
  localparam logic [3:0] EXT_OR  = 4'b0010;
  localparam logic [3:0] EXT_XOR = 4'b0011;
  localparam logic [3:0] EXT_LSH = 4'b0100;
  localparam logic [3:0] EXT_ADD = 4'b0101;
  localparam logic [3:0] EXT_SUB = 4'b1001;
  localparam logic [3:0] EXT_CMP = 4'b1011;
  localparam logic [3:0] EXT_MOV = 4'b1101;

  localparam int FLAG_L = 0;
  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 4;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    DECODE  = 2'd1,
    EXECUTE = 2'd2
  } stateType;

  typedef enum logic [3:0] {
    ALU_NOP   = 4'd0,
    ALU_AND   = 4'd1,
    ALU_OR    = 4'd2,
    ALU_XOR   = 4'd3,
    ALU_ADD   = 4'd4,
    ALU_SUB   = 4'd5,
    ALU_PASSB = 4'd6,
    ALU_SHL   = 4'd7,
    ALU_CMP   = 4'd8
  } aluOpType;

  typedef enum logic [2:0] {
    B_REG   = 3'd0,
    B_SEXT  = 3'd1,
    B_ZEXT  = 3'd2,
    B_UPPER = 3'd3,
    B_SHAMT = 3'd4
  } bSelType;

  typedef struct packed {
    aluOpType aluOp;
    bSelType  bSel;
  } decodeType;

  // MOV, MOVI and LUI all reduce to "pass operand B"; only the B source differs.
  function automatic decodeType decodeInstr(input logic [15:0] instr);
    decodeType  d;
    logic [3:0] opcode;
    logic [3:0] opext;
    d.aluOp = ALU_NOP;
    d.bSel  = B_REG;
    opcode  = instr[15:12];
    opext   = instr[7:4];
    case (opcode)
      OP_RR: begin
        case (opext)
          EXT_AND: d.aluOp = ALU_AND;
          EXT_OR:  d.aluOp = ALU_OR;
          EXT_XOR: d.aluOp = ALU_XOR;
          EXT_ADD: d.aluOp = ALU_ADD;
          EXT_SUB: d.aluOp = ALU_SUB;
          EXT_CMP: d.aluOp = ALU_CMP;
          EXT_MOV: d.aluOp = ALU_PASSB;
          default: d.aluOp = ALU_NOP;
        endcase
      end
      OP_ANDI: begin d.aluOp = ALU_AND;   d.bSel = B_ZEXT;  end
      OP_ORI:  begin d.aluOp = ALU_OR;    d.bSel = B_ZEXT;  end
      OP_XORI: begin d.aluOp = ALU_XOR;   d.bSel = B_ZEXT;  end
      OP_ADDI: begin d.aluOp = ALU_ADD;   d.bSel = B_SEXT;  end
      OP_SUBI: begin d.aluOp = ALU_SUB;   d.bSel = B_SEXT;  end
      OP_CMPI: begin d.aluOp = ALU_CMP;   d.bSel = B_SEXT;  end
      OP_MOVI: begin d.aluOp = ALU_PASSB; d.bSel = B_ZEXT;  end
      OP_LUI:  begin d.aluOp = ALU_PASSB; d.bSel = B_UPPER; end
      OP_SHIFT: begin
        if (opext == EXT_LSH) begin
          d.aluOp = ALU_SHL;
          d.bSel  = B_REG;
        end else if (opext[3:1] == 3'b000) begin
          d.aluOp = ALU_SHL;
          d.bSel  = B_SHAMT;
        end
      end
      default: d.aluOp = ALU_NOP;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/controller_data_path_alu.sv
// Combinational ALU: one result per operation plus compare flags that are
// always computed from A and B, latched only when a compare executes.
import controller_data_path_pkg::*;

module tron_alu (
  input  logic [DataWidth-1:0] a,
  input  logic [DataWidth-1:0] b,
  input  aluOpType             op,
  output logic [DataWidth-1:0] result,
  output logic [DataWidth-1:0] flags
);

  always_comb begin
    result = '0;
    case (op)
      ALU_AND:   result = a & b;
      ALU_OR:    result = a | b;
      ALU_XOR:   result = a ^ b;
      ALU_ADD:   result = a + b;
      ALU_SUB:   result = a - b;
      ALU_PASSB: result = b;
      ALU_SHL:   result = a << b[3:0];
      default:   result = '0;
    endcase
  end

  // Every bit other than L, Z and N reads as zero so a compare replaces the whole word.
  always_comb begin
    flags         = '0;
    flags[FLAG_L] = (a < b);
    flags[FLAG_Z] = (a == b);
    flags[FLAG_N] = ($signed(a) < $signed(b));
  end

endmodule

// File: rtl/controller_data_path_controller.sv
// Three-state FETCH/DECODE/EXECUTE sequencer; every control strobe is a
// register so it is glitch-free for the whole state it belongs to.
import controller_data_path_pkg::*;

module tron_controller (
  input  logic     clk,
  input  logic     reset,
  input  aluOpType aluOp,
  output logic     irLoad,
  output logic     pcInc,
  output logic     regWrite,
  output logic     flagWrite
);

  stateType state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= FETCH;
      irLoad    <= 1'b1;
      pcInc     <= 1'b0;
      regWrite  <= 1'b0;
      flagWrite <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          state  <= DECODE;
          irLoad <= 1'b0;
          pcInc  <= 1'b1;
        end
        DECODE: begin
          state     <= EXECUTE;
          pcInc     <= 1'b0;
          regWrite  <= (aluOp != ALU_NOP) && (aluOp != ALU_CMP);
          flagWrite <= (aluOp == ALU_CMP);
        end
        EXECUTE: begin
          state     <= FETCH;
          irLoad    <= 1'b1;
          regWrite  <= 1'b0;
          flagWrite <= 1'b0;
        end
        default: begin
          state     <= FETCH;
          irLoad    <= 1'b1;
          pcInc     <= 1'b0;
          regWrite  <= 1'b0;
          flagWrite <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/controller_data_path_datapath.sv
// Register file, PC, IR and flag register around the ALU; all writes are
// gated by strobes coming from the controller.
import controller_data_path_pkg::*;

module tron_datapath (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DataWidth-1:0] instruction,
  input  logic                 irLoad,
  input  logic                 pcInc,
  input  logic                 regWrite,
  input  logic                 flagWrite,
  output aluOpType             aluOp,
  output logic [DataWidth-1:0] addressOut,
  output logic [DataWidth-1:0] busOutput
);

  logic [DataWidth-1:0] regFile [RegCount];
  logic [DataWidth-1:0] pc;
  logic [DataWidth-1:0] ir;
  logic [DataWidth-1:0] flagreg;
  logic [3:0]           rd;
  logic [3:0]           rs;
  decodeType            dec;
  logic [DataWidth-1:0] opA;
  logic [DataWidth-1:0] opB;
  logic [DataWidth-1:0] aluResult;
  logic [DataWidth-1:0] aluFlags;

  assign rd         = ir[11:8];
  assign rs         = ir[3:0];
  assign dec        = decodeInstr(ir);
  assign aluOp      = dec.aluOp;
  assign opA        = regFile[rd];
  assign addressOut = pc;
  assign busOutput  = aluResult;

  always_comb begin
    opB = regFile[rs];
    case (dec.bSel)
      B_REG:   opB = regFile[rs];
      B_SEXT:  opB = {{8{ir[7]}}, ir[7:0]};
      B_ZEXT:  opB = {8'h00, ir[7:0]};
      B_UPPER: opB = {ir[7:0], 8'h00};
      B_SHAMT: opB = {12'h000, ir[3:0]};
      default: opB = regFile[rs];
    endcase
  end

  tron_alu alu (
    .a      (opA),
    .b      (opB),
    .op     (dec.aluOp),
    .result (aluResult),
    .flags  (aluFlags)
  );

  // Registers power up holding their own index so programs have known operands.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc      <= '0;
      ir      <= '0;
      flagreg <= '0;
      for (int i = 0; i < RegCount; i++) begin
        regFile[i] <= DataWidth'(i);
      end
    end else begin
      if (irLoad) begin
        ir <= instruction;
      end
      if (pcInc) begin
        pc <= pc + 16'd1;
      end
      if (regWrite) begin
        regFile[rd] <= aluResult;
      end
      if (flagWrite) begin
        flagreg <= aluFlags;
      end
    end
  end

endmodule

// File: rtl/controller_data_path.sv
// Top of the Tron processor: joins the FSM controller to the datapath.
import controller_data_path_pkg::*;

module controller_data_path (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DataWidth-1:0] instruction,
  output logic [DataWidth-1:0] addressOut,
  output logic [DataWidth-1:0] busOutput
);

  aluOpType aluOp;
  logic     irLoad;
  logic     pcInc;
  logic     regWrite;
  logic     flagWrite;

  tron_controller fsmController (
    .clk       (clk),
    .reset     (reset),
    .aluOp     (aluOp),
    .irLoad    (irLoad),
    .pcInc     (pcInc),
    .regWrite  (regWrite),
    .flagWrite (flagWrite)
  );

  tron_datapath UUTdatapath (
    .clk         (clk),
    .reset       (reset),
    .instruction (instruction),
    .irLoad      (irLoad),
    .pcInc       (pcInc),
    .regWrite    (regWrite),
    .flagWrite   (flagWrite),
    .aluOp       (aluOp),
    .addressOut  (addressOut),
    .busOutput   (busOutput)
  );

endmodule

// File: tb/tb_controller_data_path.sv
// Bench for the Tron core: a table of known instructions, hand-written reset and
// PC sequences, then random programs checked against an instruction-level model.
module tb_controller_data_path;

  logic        clk;
  logic        reset;
  logic [15:0] instruction;
  logic [15:0] addressOut;
  logic [15:0] busOutput;

  int checks;
  int errors;

  logic [15:0] mRegs [16];
  logic [15:0] mFlags;
  logic [15:0] mPc;
  logic [15:0] curInstr;

  typedef struct {
    logic [15:0] instr;
    logic [15:0] expBus;
    logic        checkFlags;
    logic [15:0] expFlags;
  } vecType;

  vecType vecs [17];

  controller_data_path dut (
    .clk         (clk),
    .reset       (reset),
    .instruction (instruction),
    .addressOut  (addressOut),
    .busOutput   (busOutput)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s instr=0x%04h actual=0x%04h expected=0x%04h", name, curInstr, actual, expected);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 16; i++) mRegs[i] = 16'(i);
    mFlags = 16'h0000;
    mPc    = 16'h0000;
  endtask

  // Instruction semantics written straight from the ISA description.
  function automatic void modelEval(input logic [15:0] instr, output logic wr, output logic fl,
                                    output logic [15:0] res, output logic [15:0] flg);
    logic [3:0]  op, rd, ext, rs;
    logic [15:0] a, b, sx, zx, cmpB;
    int          ua, ub, sa, sb, n;
    op   = instr[15:12];
    rd   = instr[11:8];
    ext  = instr[7:4];
    rs   = instr[3:0];
    a    = mRegs[rd];
    b    = mRegs[rs];
    sx   = {{8{instr[7]}}, instr[7:0]};
    zx   = {8'h00, instr[7:0]};
    wr   = 1'b0;
    fl   = 1'b0;
    res  = 16'h0000;
    flg  = mFlags;
    cmpB = 16'h0000;
    n    = -1;
    case (op)
      4'd0: case (ext)
              4'd1:  begin res = a & b; wr = 1'b1; end
              4'd2:  begin res = a | b; wr = 1'b1; end
              4'd3:  begin res = a ^ b; wr = 1'b1; end
              4'd5:  begin res = 16'((int'(a) + int'(b)) % 65536); wr = 1'b1; end
              4'd9:  begin res = 16'((int'(a) - int'(b) + 65536) % 65536); wr = 1'b1; end
              4'd11: begin fl = 1'b1; cmpB = b; end
              4'd13: begin res = b; wr = 1'b1; end
              default: ;
            endcase
      4'd1:  begin res = a & zx; wr = 1'b1; end
      4'd2:  begin res = a | zx; wr = 1'b1; end
      4'd3:  begin res = a ^ zx; wr = 1'b1; end
      4'd5:  begin res = 16'((int'(a) + int'(sx)) % 65536); wr = 1'b1; end
      4'd9:  begin res = 16'((int'(a) - int'(sx) + 65536) % 65536); wr = 1'b1; end
      4'd11: begin fl = 1'b1; cmpB = sx; end
      4'd13: begin res = zx; wr = 1'b1; end
      4'd15: begin res = 16'(int'(instr[7:0]) * 256); wr = 1'b1; end
      4'd8: begin
        if (ext == 4'd4) n = int'(b[3:0]);
        else if (ext < 4'd2) n = int'(rs);
      end
      default: ;
    endcase
    if (n >= 0) begin
      res = 16'((longint'(a) * (longint'(1) << n)) % 65536);
      wr  = 1'b1;
    end
    if (fl) begin
      ua  = int'(a);
      ub  = int'(cmpB);
      sa  = (ua >= 32768) ? ua - 65536 : ua;
      sb  = (ub >= 32768) ? ub - 65536 : ub;
      flg = 16'h0000;
      if (ua < ub) flg = flg + 16'd1;
      if (ua == ub) flg = flg + 16'd8;
      if (sa < sb) flg = flg + 16'd16;
    end
  endfunction

  // Runs one instruction from the start of FETCH to the start of the next FETCH.
  task automatic applyStimulus(input logic [15:0] instr, output logic [15:0] busSeen);
    logic        wr, fl;
    logic [15:0] res, flg;
    logic [3:0]  rd;
    curInstr = instr;
    rd       = instr[11:8];
    modelEval(instr, wr, fl, res, flg);
    instruction = instr;
    @(posedge clk); #1;
    checkOutput("regWrite in DECODE", {15'b0, dut.fsmController.regWrite}, 16'h0000);
    checkOutput("addressOut in DECODE", addressOut, mPc);
    instruction = 16'($urandom);
    @(posedge clk); #1;
    mPc     = mPc + 16'd1;
    busSeen = busOutput;
    checkOutput("addressOut in EXECUTE", addressOut, mPc);
    checkOutput("regWrite in EXECUTE", {15'b0, dut.fsmController.regWrite}, {15'b0, wr});
    if (wr) checkOutput("busOutput", busOutput, res);
    @(posedge clk); #1;
    if (wr) mRegs[rd] = res;
    if (fl) mFlags = flg;
    checkOutput("flagreg", dut.UUTdatapath.flagreg, mFlags);
    checkOutput("Rdest value", dut.UUTdatapath.regFile[rd], mRegs[rd]);
  endtask

  task automatic doReset();
    reset       = 1'b1;
    instruction = 16'h0000;
    @(posedge clk); #1;
    reset = 1'b0;
    modelReset();
  endtask

  initial begin
    logic [15:0] bus;
    logic [15:0] r;
    logic [3:0]  extPick [10];
    checks   = 0;
    errors   = 0;
    curInstr = 16'h0000;
    reset    = 1'b1;
    instruction = 16'h0000;

    vecs[0]  = '{16'h0152, 16'h0003, 1'b0, 16'h0000};
    vecs[1]  = '{16'h0192, 16'hFFFF, 1'b0, 16'h0000};
    vecs[2]  = '{16'h0113, 16'h0001, 1'b0, 16'h0000};
    vecs[3]  = '{16'h0122, 16'h0003, 1'b0, 16'h0000};
    vecs[4]  = '{16'h013E, 16'h000F, 1'b0, 16'h0000};
    vecs[5]  = '{16'h01D5, 16'h0005, 1'b0, 16'h0000};
    vecs[6]  = '{16'h5193, 16'hFF94, 1'b0, 16'h0000};
    vecs[7]  = '{16'h9101, 16'h0000, 1'b0, 16'h0000};
    vecs[8]  = '{16'h210E, 16'h000F, 1'b0, 16'h0000};
    vecs[9]  = '{16'h310E, 16'h000F, 1'b0, 16'h0000};
    vecs[10] = '{16'h1102, 16'h0000, 1'b0, 16'h0000};
    vecs[11] = '{16'hF101, 16'h0100, 1'b0, 16'h0000};
    vecs[12] = '{16'h01B1, 16'h0000, 1'b1, 16'h0008};
    vecs[13] = '{16'hB102, 16'h0000, 1'b1, 16'h0011};
    vecs[14] = '{16'h8143, 16'h0008, 1'b0, 16'h0000};
    vecs[15] = '{16'h8101, 16'h0002, 1'b0, 16'h0000};
    vecs[16] = '{16'h8111, 16'h0002, 1'b0, 16'h0000};

    doReset();
    checkOutput("reset addressOut", addressOut, 16'h0000);
    checkOutput("reset busOutput", busOutput, 16'h0000);
    checkOutput("reset flagreg", dut.UUTdatapath.flagreg, 16'h0000);
    checkOutput("reset regWrite", {15'b0, dut.fsmController.regWrite}, 16'h0000);
    for (int i = 0; i < 16; i++) begin
      r = dut.UUTdatapath.regFile[i];
      checkOutput("reset register", r, 16'(i));
    end

    for (int i = 0; i < 17; i++) begin
      applyStimulus(16'hD101, bus);
      applyStimulus(vecs[i].instr, bus);
      if (vecs[i].checkFlags) checkOutput("table flagreg", dut.UUTdatapath.flagreg, vecs[i].expFlags);
      else checkOutput("table busOutput", bus, vecs[i].expBus);
    end

    doReset();
    for (int i = 0; i < 17; i++) begin
      applyStimulus({4'b0111, 12'($urandom)}, bus);
    end
    checkOutput("PC after 17 instructions", addressOut, 16'h0011);

    doReset();
    curInstr    = 16'hD355;
    instruction = 16'hD355;
    @(posedge clk); #1;
    checkOutput("regWrite before abort", {15'b0, dut.fsmController.regWrite}, 16'h0000);
    reset = 1'b1;
    #1;
    checkOutput("PC on mid-instruction reset", addressOut, 16'h0000);
    @(posedge clk); #1;
    reset = 1'b0;
    modelReset();
    @(posedge clk); #1;
    checkOutput("regWrite after abort", {15'b0, dut.fsmController.regWrite}, 16'h0000);
    checkOutput("PC after abort", addressOut, 16'h0000);
    for (int i = 0; i < 16; i++) begin
      r = dut.UUTdatapath.regFile[i];
      checkOutput("register after abort", r, 16'(i));
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("PC after aborted restart", addressOut, 16'h0001);
    doReset();

    extPick = '{4'd1, 4'd2, 4'd3, 4'd5, 4'd9, 4'd11, 4'd13, 4'd4, 4'd0, 4'd1};
    for (int i = 0; i < 200; i++) begin
      r = 16'($urandom);
      if ((r[15:12] == 4'd0 || r[15:12] == 4'd8) && $urandom_range(0, 3) != 0)
        r[7:4] = extPick[$urandom_range(0, 9)];
      applyStimulus(r, bus);
    end
    for (int i = 0; i < 16; i++) begin
      r = dut.UUTdatapath.regFile[i];
      checkOutput("final register file", r, mRegs[i]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/controller_data_path.md
# controller_data_path

- Single-issue, multi-cycle 16-bit CPU core.
- Each instruction is taken from an external `instruction` port; there is no internal instruction memory.
- The core decodes and executes it on a 16×16 register file.
- It exposes the program counter as `addressOut` and the write-back bus as `busOutput`.
- It is the top of the Tron processor, joining the FSM controller and the datapath.

## Interface
- No parameters. Data width 16, 16 registers, 4-bit register indices, all fixed.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `instruction` in 16: current instruction word; sampled at the end of FETCH.
- `addressOut` out 16: program counter.
- `busOutput` out 16: write-back bus, i.e. the value written to Rdest when regWrite=1.

## Operation
- **Field layout:** [15:12] opcode, [11:8] Rdest, [7:4] opext, [3:0] Rsrc; imm8 = [7:0].
- **Immediate extension:**
  - Sign-extended for ADDI, SUBI, CMPI.
  - Zero-extended for ANDI, ORI, XORI, MOVI.
- **Opcode 0000 (register-register), selected by opext:**
  - 0001 AND.
  - 0010 OR.
  - 0011 XOR.
  - 0101 ADD.
  - 1001 SUB (Rdest−Rsrc).
  - 1011 CMP (flags only).
  - 1101 MOV (Rdest=Rsrc).
  - Any other opext: NOP.
- **Immediate opcodes:**
  - 0001 ANDI.
  - 0010 ORI.
  - 0011 XORI.
  - 0101 ADDI.
  - 1001 SUBI.
  - 1011 CMPI.
  - 1101 MOVI.
  - 1111 LUI: Rdest = {imm8, 8'h00}.
- **Opcode 1000 (shifts):**
  - opext 0100 LSH: Rdest = Rdest << Rsrc[3:0].
  - opext[7:5]=000 LSHI: Rdest = Rdest << instr[3:0]; instr[4] ignored.
  - Other opext: NOP.
- All other opcodes are NOP: no register write, no flag change, PC still increments.
- Arithmetic is modulo 2^16. ADD/SUB do not modify flags.
- **Flag register `flagreg` (16 bits):**
  - Written only by CMP/CMPI, comparing Rdest against the operand B (Rsrc or sign-extended imm8).
  - Bit0 L = Rdest < B unsigned.
  - Bit3 Z = equal.
  - Bit4 N = Rdest < B signed.
  - All other bits written 0; the whole register is replaced on each compare.
- **Reset (asynchronous):**
  - PC=0, state=FETCH, flagreg=0, IR=0.
  - Register file r[i]=i, for i=0..15.
  - busOutput reflects the ALU result of IR=0, i.e. 0.

## Timing
- **FSM:** FETCH → DECODE → EXECUTE → FETCH. Exactly 3 cycles per instruction, no stalls.
- **FETCH:** IR ← instruction at the closing edge. `instruction` need only be stable during FETCH.
- **DECODE:** operands read. PC ← PC+1 at the closing edge, so addressOut increments once per instruction, visible from EXECUTE on.
- **EXECUTE:**
  - regWrite=1 for write-back ops; busOutput = result.
  - Rdest and flagreg update at the closing edge.
  - regWrite=0 in FETCH and DECODE, and for CMP/CMPI/NOP.
- **PC:** wraps FFFF → 0000.
- **Reset mid-instruction:** aborts it with no write and returns to FETCH/PC=0.
- **Same-cycle hazards:** none; operands are read at least a full cycle after the previous write.

## Structure
- **Shared package:**
  - Opcode and opext constants.
  - FSM state encoding (FETCH/DECODE/EXECUTE).
  - Flag bit indices L=0, Z=3, N=4.
- **Top level:** instantiates controller `fsmController`, which exposes `regWrite`, and datapath `UUTdatapath`, which holds `flagreg`, the register file, PC and IR. These hierarchical names are kept for verification probes.
- **Natural sub-module:** `tron_alu`, combinational, (A, B, op) → result and compare flags.

## Test plan
- **ADD then reg-reg ops:** reset, release, instruction 0x0152 (ADD r1,r2).
  - In EXECUTE: addressOut=0x0001, regWrite=1, busOutput=0x0003.
  - Then MOVI r1,1 (0xD101) restores r1; repeat with each of the following, each → busOutput in EXECUTE:
    - SUB 0x0192 → 0xFFFF.
    - AND 0x0113 → 0x0001.
    - OR 0x0122 → 0x0003.
    - XOR 0x013E → 0x000F.
    - MOV 0x01D5 → 0x0005.
- **Immediates:** with r1=1, each → busOutput in EXECUTE:
  - ADDI 0x5193 → 0xFF94.
  - SUBI 0x9101 → 0x0000.
  - ORI 0x210E → 0x000F.
  - XORI 0x310E → 0x000F.
  - ANDI 0x1102 → 0x0000.
  - LUI 0xF101 → 0x0100.
- **Compares:** CMP 0x01B1 → flagreg=0x0008, regWrite=0 throughout. CMPI 0xB102 → flagreg=0x0011.
- **Shifts:** with r1=1:
  - LSH 0x8143 → 0x0008.
  - LSHI 0x8101 → 0x0002.
  - LSHI 0x8111 → 0x0002.
- **PC and reset:** 17 consecutive instructions → addressOut=0x0011, incrementing exactly every 3 clocks. Asserting reset in DECODE → PC=0, no register write, registers back to r[i]=i.
